// File: rtl/sprite_drawer.sv
// ---------------------------------------------------------------------------
// sprite_drawer
//
// Responder side of the character move/draw handshake. A level-held drawBG or
// drawChar request (drawBG has priority) starts a job that streams a
// SPRITE_W x SPRITE_H block of pixels into the 320x240 VGA adapter. Pixels
// come from either the character ROM or the full-screen background ROM. On
// completion a one-cycle doneBG/doneChar pulse is returned. The FSM then
// waits for both requests to drop, so a held request cannot retrigger.
//
// Ports
//   clock, resetn              system clock, synchronous active-low reset
//   drawChar, drawBG           level-held job requests
//   xCoordinate, yCoordinate   sprite top-left corner (latched at job start)
//   doneChar, doneBG           one-cycle completion pulses
//   char_addr / char_data      character ROM port, data valid one cycle
//                              after the address
//   bg_addr / bg_data          background ROM port (y*320 + x), data valid
//                              one cycle after the address
//   vga_x, vga_y, vga_colour   pixel plot position and colour
//   vga_plot                   VGA write enable
//   busy                       high whenever the FSM is not idle
//
// Build option
//   SPRITE_TRANSPARENCY_EN     when defined, character pixels equal to
//                              TRANSPARENT_COLOUR are not plotted
// ---------------------------------------------------------------------------
module sprite_drawer #(
  parameter int                     SPRITE_W           = 8,
  parameter int                     SPRITE_H           = 8,
  parameter int                     COLOUR_BITS        = 9,
  parameter logic [COLOUR_BITS-1:0] TRANSPARENT_COLOUR = '0
) (
  input  logic                                    clock,
  input  logic                                    resetn,
  input  logic                                    drawChar,
  input  logic                                    drawBG,
  input  logic [8:0]                              xCoordinate,
  input  logic [7:0]                              yCoordinate,
  output logic                                    doneChar,
  output logic                                    doneBG,
  output logic [$clog2(SPRITE_W*SPRITE_H)-1:0]    char_addr,
  input  logic [COLOUR_BITS-1:0]                  char_data,
  output logic [16:0]                             bg_addr,
  input  logic [COLOUR_BITS-1:0]                  bg_data,
  output logic [8:0]                              vga_x,
  output logic [7:0]                              vga_y,
  output logic [COLOUR_BITS-1:0]                  vga_colour,
  output logic                                    vga_plot,
  output logic                                    busy
);

  localparam int CX_W     = $clog2(SPRITE_W);
  localparam int CY_W     = $clog2(SPRITE_H);
  localparam int SCREEN_W = 320;
  localparam int SCREEN_H = 240;

  localparam logic [CX_W-1:0] CX_LAST = CX_W'(SPRITE_W - 1);
  localparam logic [CY_W-1:0] CY_LAST = CY_W'(SPRITE_H - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_FETCH,
    S_DRAIN,
    S_DONE,
    S_RELEASE
  } state_t;

  state_t r_state;
  state_t w_next;

  // Job context, latched once per job.
  logic [8:0]      r_x0;
  logic [7:0]      r_y0;
  logic            r_job_bg;
  logic [CX_W-1:0] r_cx;
  logic [CY_W-1:0] r_cy;

  // Current pixel position, one bit wider than the screen coordinates so a
  // sprite hanging off the right/bottom edge never wraps back on screen.
  logic [9:0] w_px;
  logic [8:0] w_py;
  logic       w_on_screen;
  logic       w_last;
  logic       w_fetch;

  // Stage p0: registered together with the ROM address.
  logic       r_vld_p0;
  logic       r_in_p0;
  logic       r_bg_p0;
  logic [8:0] r_px_p0;
  logic [7:0] r_py_p0;

  // Stage p1: aligned with the ROM read data.
  logic       r_vld_p1;
  logic       r_in_p1;
  logic       r_bg_p1;
  logic [8:0] r_px_p1;
  logic [7:0] r_py_p1;

  logic                                 r_doneChar;
  logic                                 r_doneBG;
  logic [$clog2(SPRITE_W*SPRITE_H)-1:0] r_char_addr;
  logic [16:0]                          r_bg_addr;

  logic [COLOUR_BITS-1:0] w_src;
  logic                   w_key_match;
  logic                   w_key;

  function automatic logic f_on_screen(input logic [9:0] px, input logic [8:0] py);
    return (px < 10'(SCREEN_W)) && (py < 9'(SCREEN_H));
  endfunction

  // Linear background address; only used for on-screen pixels, where the
  // result always fits in 17 bits.
  function automatic logic [16:0] f_bg_addr(input logic [9:0] px, input logic [8:0] py);
    return 17'(py) * 17'(SCREEN_W) + 17'(px);
  endfunction

  // -------------------------------------------------------------------------
  // FSM state register
  // -------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (!resetn) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (drawBG || drawChar) begin
          w_next = S_LOAD;
        end
      end
      S_LOAD:  w_next = S_FETCH;
      S_FETCH: begin
        if (w_last) begin
          w_next = S_DRAIN;
        end
      end
      S_DRAIN: w_next = S_DONE;
      S_DONE:  w_next = S_RELEASE;
      S_RELEASE: begin
        // Both requests must be low before another job can start.
        if (!drawBG && !drawChar) begin
          w_next = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  assign w_fetch     = (r_state == S_FETCH);
  assign w_last      = (r_cx == CX_LAST) && (r_cy == CY_LAST);
  assign w_px        = 10'(r_x0) + 10'(r_cx);
  assign w_py        = 9'(r_y0) + 9'(r_cy);
  assign w_on_screen = f_on_screen(w_px, w_py);

  // -------------------------------------------------------------------------
  // Job context and pixel walk (cx fastest)
  // -------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (!resetn) begin
      r_x0     <= '0;
      r_y0     <= '0;
      r_job_bg <= 1'b0;
      r_cx     <= '0;
      r_cy     <= '0;
    end else begin
      if (r_state == S_LOAD) begin
        r_x0     <= xCoordinate;
        r_y0     <= yCoordinate;
        r_job_bg <= drawBG;
        r_cx     <= '0;
        r_cy     <= '0;
      end else if (w_fetch) begin
        if (r_cx == CX_LAST) begin
          r_cx <= '0;
          r_cy <= r_cy + 1'b1;
        end else begin
          r_cx <= r_cx + 1'b1;
        end
      end
    end
  end

  // -------------------------------------------------------------------------
  // Stage p0: ROM address issue
  // -------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (!resetn) begin
      r_vld_p0    <= 1'b0;
      r_in_p0     <= 1'b0;
      r_bg_p0     <= 1'b0;
      r_px_p0     <= '0;
      r_py_p0     <= '0;
      r_char_addr <= '0;
      r_bg_addr   <= '0;
    end else begin
      r_vld_p0 <= w_fetch;
      r_in_p0  <= w_on_screen;
      r_bg_p0  <= r_job_bg;
      r_px_p0  <= w_px[8:0];
      r_py_p0  <= w_py[7:0];
      // Only the active job's ROM sees a live address; off-screen pixels and
      // non-fetch cycles park both addresses at 0.
      r_char_addr <= (w_fetch && !r_job_bg && w_on_screen) ? {r_cy, r_cx} : '0;
      r_bg_addr   <= (w_fetch &&  r_job_bg && w_on_screen) ? f_bg_addr(w_px, w_py) : '0;
    end
  end

  // -------------------------------------------------------------------------
  // Stage p1: aligned with ROM data, drives the VGA adapter
  // -------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (!resetn) begin
      r_vld_p1 <= 1'b0;
      r_in_p1  <= 1'b0;
      r_bg_p1  <= 1'b0;
      r_px_p1  <= '0;
      r_py_p1  <= '0;
    end else begin
      r_vld_p1 <= r_vld_p0;
      r_in_p1  <= r_in_p0;
      r_bg_p1  <= r_bg_p0;
      r_px_p1  <= r_px_p0;
      r_py_p1  <= r_py_p0;
    end
  end

  // -------------------------------------------------------------------------
  // Completion pulses
  // -------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (!resetn) begin
      r_doneChar <= 1'b0;
      r_doneBG   <= 1'b0;
    end else begin
      r_doneBG   <= (r_state == S_DONE) &&  r_job_bg;
      r_doneChar <= (r_state == S_DONE) && !r_job_bg;
    end
  end

  assign w_src       = r_bg_p1 ? bg_data : char_data;
  assign w_key_match = (char_data == TRANSPARENT_COLOUR);

`ifdef SPRITE_TRANSPARENCY_EN
  // Colour-keyed character pixels are dropped; background jobs are opaque.
  assign w_key = !r_bg_p1 && w_key_match;
`else
  // Every on-screen pixel is opaque; the key comparison has no effect.
  assign w_key = 1'b0 & w_key_match;
`endif

  assign vga_x      = r_px_p1;
  assign vga_y      = r_py_p1;
  assign vga_colour = r_vld_p1 ? w_src : '0;
  assign vga_plot   = r_vld_p1 && r_in_p1 && !w_key;
  assign char_addr  = r_char_addr;
  assign bg_addr    = r_bg_addr;
  assign doneChar   = r_doneChar;
  assign doneBG     = r_doneBG;
  assign busy       = (r_state != S_IDLE);

endmodule

// File: tb/tb_sprite_drawer.sv
// ---------------------------------------------------------------------------
// tb_sprite_drawer
//
// Self-checking bench for sprite_drawer. Synchronous ROM models feed the DUT;
// a monitor records every plot, done pulse and ROM address per clock edge.
// Each scenario task compares those records against a pixel-level model of
// the block walk, clipping and colour keying.
// ---------------------------------------------------------------------------
module tb_sprite_drawer;

  localparam int W  = 8;
  localparam int H  = 8;
  localparam int N  = W * H;
  localparam int CB = 9;
  localparam int HN = 4096;

`ifdef SPRITE_TRANSPARENCY_EN
  localparam bit TRANSP = 1'b1;
`else
  localparam bit TRANSP = 1'b0;
`endif

  logic          clock = 1'b0;
  logic          resetn = 1'b0;
  logic          drawChar = 1'b0;
  logic          drawBG = 1'b0;
  logic [8:0]    xCoordinate = '0;
  logic [7:0]    yCoordinate = '0;
  logic          doneChar;
  logic          doneBG;
  logic [5:0]    char_addr;
  logic [CB-1:0] char_data;
  logic [16:0]   bg_addr;
  logic [CB-1:0] bg_data;
  logic [8:0]    vga_x;
  logic [7:0]    vga_y;
  logic [CB-1:0] vga_colour;
  logic          vga_plot;
  logic          busy;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  typedef struct packed {
    logic [31:0] cyc;
    logic [31:0] x;
    logic [31:0] y;
    logic [31:0] col;
  } pix_t;

  pix_t got_q[$];
  pix_t exp_q[$];
  int   dbg_q[$];
  int   dch_q[$];

  logic [16:0]   bg_hist [HN];
  logic [5:0]    ch_hist [HN];
  logic [16:0]   exp_bg  [N];
  logic [5:0]    exp_ch  [N];
  logic [CB-1:0] char_rom [N];

  sprite_drawer #(
    .SPRITE_W(W), .SPRITE_H(H), .COLOUR_BITS(CB), .TRANSPARENT_COLOUR(9'd0)
  ) dut (
    .clock(clock), .resetn(resetn), .drawChar(drawChar), .drawBG(drawBG),
    .xCoordinate(xCoordinate), .yCoordinate(yCoordinate),
    .doneChar(doneChar), .doneBG(doneBG),
    .char_addr(char_addr), .char_data(char_data),
    .bg_addr(bg_addr), .bg_data(bg_data),
    .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour),
    .vga_plot(vga_plot), .busy(busy)
  );

  always #5 clock = ~clock;

  function automatic logic [CB-1:0] bg_fn(input int a);
    return CB'((a * 37 + 11) % 509 + 1);
  endfunction

  // Synchronous ROMs: data appears the cycle after the address.
  always @(posedge clock) begin
    char_data <= char_rom[char_addr];
    bg_data   <= bg_fn(int'(bg_addr));
    cyc       <= cyc + 1;
  end

  always @(negedge clock) begin
    if (vga_plot === 1'b1)
      got_q.push_back(pix_t'{32'(cyc), 32'(vga_x), 32'(vga_y), 32'(vga_colour)});
    if (doneBG === 1'b1) dbg_q.push_back(cyc);
    if (doneChar === 1'b1) dch_q.push_back(cyc);
    bg_hist[cyc % HN] <= bg_addr;
    ch_hist[cyc % HN] <= char_addr;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  // Raise a request; t is the clock edge at which the idle DUT samples it.
  task automatic launch(input bit bg, input bit ch, input int x, input int y, output int t);
    @(negedge clock);
    got_q.delete();
    dbg_q.delete();
    dch_q.delete();
    xCoordinate = 9'(x);
    yCoordinate = 8'(y);
    drawBG      = bg;
    drawChar    = ch;
    t           = cyc + 1;
  endtask

  task automatic release_req();
    drawBG   = 1'b0;
    drawChar = 1'b0;
    repeat (2) @(negedge clock);
  endtask

  // Expected plots and ROM addresses for one job starting at edge t.
  task automatic model(input bit bg, input int x, input int y, input int t);
    exp_q.delete();
    for (int i = 0; i < N; i++) begin
      int px;
      int py;
      int col;
      bit on;
      px = x + (i % W);
      py = y + (i / W);
      on = (px < 320) && (py < 240);
      exp_bg[i] = (bg && on) ? 17'(py * 320 + px) : 17'd0;
      exp_ch[i] = (!bg && on) ? 6'(i) : 6'd0;
      col = bg ? int'(bg_fn(py * 320 + px)) : int'(char_rom[i]);
      if (on && !(TRANSP && !bg && col == 0))
        exp_q.push_back(pix_t'{32'(t + 3 + i), 32'(px), 32'(py), 32'(col)});
    end
  endtask

  task automatic fill_char_rom();
    for (int i = 0; i < N; i++) char_rom[i] = CB'($urandom_range(0, 511));
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    repeat (3) @(negedge clock);
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++;
    if ({vga_plot, doneBG, doneChar} !== 3'b000) begin
      failures++; $display("FAIL reset_ctl got=%b exp=000", {vga_plot, doneBG, doneChar});
    end
    checks++;
    if ({vga_x, vga_y, vga_colour} !== 26'd0) begin
      failures++; $display("FAIL reset_pix got=%h exp=0", {vga_x, vga_y, vga_colour});
    end
    checks++;
    if ({char_addr, bg_addr} !== 23'd0) begin
      failures++; $display("FAIL reset_addr got=%h exp=0", {char_addr, bg_addr});
    end
    resetn = 1'b1;
    repeat (3) @(negedge clock);
    checks++;
    if ({busy, vga_plot} !== 2'b00) begin
      failures++; $display("FAIL reset_idle got=%b exp=00", {busy, vga_plot});
    end
  endtask

  task automatic test_bg();
    int t;
    launch(1'b1, 1'b0, 95, 221, t);
    model(1'b1, 95, 221, t);
    repeat (10) @(negedge clock);
    checks++;
    if (busy !== 1'b1) begin failures++; $display("FAIL bg_busy got=%b exp=1", busy); end
    repeat (62) @(negedge clock);
    release_req();
    checks++;
    if (bg_hist[(t + 2) % HN] !== 17'd70815) begin
      failures++; $display("FAIL bg_first_addr got=%0d exp=70815", bg_hist[(t + 2) % HN]);
    end
    checks++;
    if (got_q.size() != 64) begin failures++; $display("FAIL bg_count got=%0d exp=64", got_q.size()); end
    checks++;
    if (got_q.size() == 0 || got_q[0].cyc != t + 3 || got_q[0].x != 95 || got_q[0].y != 221) begin
      failures++; $display("FAIL bg_first_plot got=%0d:(%0d,%0d) exp=%0d:(95,221)",
                           got_q[0].cyc, got_q[0].x, got_q[0].y, t + 3);
    end
    checks++;
    if (got_q.size() == 0 || got_q[$].cyc != t + 66 || got_q[$].x != 102 || got_q[$].y != 228) begin
      failures++; $display("FAIL bg_last_plot got=%0d:(%0d,%0d) exp=%0d:(102,228)",
                           got_q[$].cyc, got_q[$].x, got_q[$].y, t + 66);
    end
    foreach (exp_q[k]) if (k < got_q.size()) begin
      checks++;
      if (got_q[k] !== exp_q[k]) begin
        failures++; $display("FAIL bg_pix[%0d] got=%h exp=%h", k, got_q[k], exp_q[k]);
      end
    end
    checks++;
    if (dbg_q.size() != 1 || dbg_q[0] != t + 67) begin
      failures++; $display("FAIL bg_done got=%0d@%0d exp=1@%0d", dbg_q.size(), dbg_q[0], t + 67);
    end
    checks++;
    if (dch_q.size() != 0) begin failures++; $display("FAIL bg_donechar got=%0d exp=0", dch_q.size()); end
  endtask

  task automatic test_char();
    int t;
    fill_char_rom();
    for (int i = 0; i < N; i++) char_rom[i] = (i < W) ? CB'(0) : CB'($urandom_range(1, 511));
    launch(1'b0, 1'b1, 126, 68, t);
    model(1'b0, 126, 68, t);
    repeat (72) @(negedge clock);
    release_req();
    for (int i = 0; i < N; i++) begin
      checks++;
      if (ch_hist[(t + 2 + i) % HN] !== exp_ch[i] || bg_hist[(t + 2 + i) % HN] !== exp_bg[i]) begin
        failures++; $display("FAIL char_addr[%0d] got=%0d/%0d exp=%0d/%0d", i,
                             ch_hist[(t + 2 + i) % HN], bg_hist[(t + 2 + i) % HN], exp_ch[i], exp_bg[i]);
      end
    end
    checks++;
    if (got_q.size() != (TRANSP ? 56 : 64)) begin
      failures++; $display("FAIL char_count got=%0d exp=%0d", got_q.size(), TRANSP ? 56 : 64);
    end
    foreach (exp_q[k]) if (k < got_q.size()) begin
      checks++;
      if (got_q[k] !== exp_q[k]) begin
        failures++; $display("FAIL char_pix[%0d] got=%h exp=%h", k, got_q[k], exp_q[k]);
      end
    end
    checks++;
    if (dch_q.size() != 1 || dch_q[0] != t + 67) begin
      failures++; $display("FAIL char_done got=%0d@%0d exp=1@%0d", dch_q.size(), dch_q[0], t + 67);
    end
    checks++;
    if (dbg_q.size() != 0) begin failures++; $display("FAIL char_donebg got=%0d exp=0", dbg_q.size()); end
  endtask

  task automatic test_clip();
    int t;
    launch(1'b1, 1'b0, 316, 236, t);
    model(1'b1, 316, 236, t);
    repeat (72) @(negedge clock);
    release_req();
    for (int i = 0; i < N; i++) begin
      checks++;
      if (bg_hist[(t + 2 + i) % HN] !== exp_bg[i]) begin
        failures++; $display("FAIL clip_addr[%0d] got=%0d exp=%0d", i, bg_hist[(t + 2 + i) % HN], exp_bg[i]);
      end
    end
    checks++;
    if (got_q.size() != 16) begin failures++; $display("FAIL clip_count got=%0d exp=16", got_q.size()); end
    foreach (exp_q[k]) if (k < got_q.size()) begin
      checks++;
      if (got_q[k] !== exp_q[k]) begin
        failures++; $display("FAIL clip_pix[%0d] got=%h exp=%h", k, got_q[k], exp_q[k]);
      end
    end
    checks++;
    if (dbg_q.size() != 1 || dbg_q[0] != t + 67) begin
      failures++; $display("FAIL clip_done got=%0d@%0d exp=1@%0d", dbg_q.size(), dbg_q[0], t + 67);
    end
  endtask

  task automatic test_both();
    int t;
    int x;
    int y;
    fill_char_rom();
    x = $urandom_range(0, 300);
    y = $urandom_range(0, 220);
    launch(1'b1, 1'b1, x, y, t);
    model(1'b1, x, y, t);
    repeat (72) @(negedge clock);
    drawBG = 1'b0;
    repeat (10) @(negedge clock);
    checks++;
    if (got_q.size() != exp_q.size()) begin
      failures++; $display("FAIL both_count got=%0d exp=%0d", got_q.size(), exp_q.size());
    end
    foreach (exp_q[k]) if (k < got_q.size()) begin
      checks++;
      if (got_q[k] !== exp_q[k]) begin
        failures++; $display("FAIL both_pix[%0d] got=%h exp=%h", k, got_q[k], exp_q[k]);
      end
    end
    checks++;
    if (dbg_q.size() != 1 || dbg_q[0] != t + 67 || dch_q.size() != 0) begin
      failures++; $display("FAIL both_done got=bg%0d/ch%0d exp=bg1/ch0", dbg_q.size(), dch_q.size());
    end
    checks++;
    if (busy !== 1'b1) begin failures++; $display("FAIL both_release_busy got=%b exp=1", busy); end
    drawChar = 1'b0;
    repeat (2) @(negedge clock);
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL both_idle got=%b exp=0", busy); end
    x = $urandom_range(0, 300);
    y = $urandom_range(0, 220);
    launch(1'b0, 1'b1, x, y, t);
    model(1'b0, x, y, t);
    repeat (72) @(negedge clock);
    release_req();
    checks++;
    if (got_q.size() != exp_q.size()) begin
      failures++; $display("FAIL both_char_count got=%0d exp=%0d", got_q.size(), exp_q.size());
    end
    foreach (exp_q[k]) if (k < got_q.size()) begin
      checks++;
      if (got_q[k] !== exp_q[k]) begin
        failures++; $display("FAIL both_char_pix[%0d] got=%h exp=%h", k, got_q[k], exp_q[k]);
      end
    end
    checks++;
    if (dch_q.size() != 1 || dch_q[0] != t + 67 || dbg_q.size() != 0) begin
      failures++; $display("FAIL both_char_done got=ch%0d/bg%0d exp=ch1/bg0", dch_q.size(), dbg_q.size());
    end
  endtask

  task automatic test_held();
    int t;
    launch(1'b1, 1'b0, 40, 50, t);
    model(1'b1, 40, 50, t);
    repeat (88) @(negedge clock);
    release_req();
    checks++;
    if (got_q.size() != 64) begin failures++; $display("FAIL held_count got=%0d exp=64", got_q.size()); end
    foreach (exp_q[k]) if (k < got_q.size()) begin
      checks++;
      if (got_q[k] !== exp_q[k]) begin
        failures++; $display("FAIL held_pix[%0d] got=%h exp=%h", k, got_q[k], exp_q[k]);
      end
    end
    checks++;
    if (dbg_q.size() != 1 || dbg_q[0] != t + 67) begin
      failures++; $display("FAIL held_done got=%0d@%0d exp=1@%0d", dbg_q.size(), dbg_q[0], t + 67);
    end
  endtask

  task automatic test_midreset();
    int t;
    launch(1'b1, 1'b0, 10, 20, t);
    model(1'b1, 10, 20, t);
    while (cyc < t + 29) @(negedge clock);
    resetn = 1'b0;
    @(negedge clock);
    checks++;
    if ({busy, vga_plot, doneBG, doneChar} !== 4'b0000) begin
      failures++; $display("FAIL mid_ctl got=%b exp=0000", {busy, vga_plot, doneBG, doneChar});
    end
    checks++;
    if ({vga_x, vga_y, vga_colour, char_addr, bg_addr} !== 49'd0) begin
      failures++; $display("FAIL mid_data got=%h exp=0", {vga_x, vga_y, vga_colour, char_addr, bg_addr});
    end
    resetn = 1'b1;
    drawBG = 1'b0;
    repeat (70) @(negedge clock);
    checks++;
    if (got_q.size() != 27) begin failures++; $display("FAIL mid_partial got=%0d exp=27", got_q.size()); end
    foreach (got_q[k]) if (k < 27) begin
      checks++;
      if (got_q[k] !== exp_q[k]) begin
        failures++; $display("FAIL mid_pix[%0d] got=%h exp=%h", k, got_q[k], exp_q[k]);
      end
    end
    checks++;
    if (dbg_q.size() + dch_q.size() != 0) begin
      failures++; $display("FAIL mid_nodone got=%0d exp=0", dbg_q.size() + dch_q.size());
    end
    launch(1'b1, 1'b0, 200, 100, t);
    model(1'b1, 200, 100, t);
    repeat (72) @(negedge clock);
    release_req();
    checks++;
    if (got_q.size() != 64) begin failures++; $display("FAIL mid_redo_count got=%0d exp=64", got_q.size()); end
    foreach (exp_q[k]) if (k < got_q.size()) begin
      checks++;
      if (got_q[k] !== exp_q[k]) begin
        failures++; $display("FAIL mid_redo_pix[%0d] got=%h exp=%h", k, got_q[k], exp_q[k]);
      end
    end
    checks++;
    if (dbg_q.size() != 1 || dbg_q[0] != t + 67) begin
      failures++; $display("FAIL mid_redo_done got=%0d@%0d exp=1@%0d", dbg_q.size(), dbg_q[0], t + 67);
    end
  endtask

  task automatic test_random();
    for (int j = 0; j < 6; j++) begin
      int t;
      int x;
      int y;
      bit bg;
      fill_char_rom();
      bg = 1'($urandom_range(0, 1));
      x  = $urandom_range(0, 330);
      y  = $urandom_range(0, 245);
      launch(bg, !bg, x, y, t);
      model(bg, x, y, t);
      repeat (72) @(negedge clock);
      release_req();
      for (int i = 0; i < N; i++) begin
        checks++;
        if (bg_hist[(t + 2 + i) % HN] !== exp_bg[i] || ch_hist[(t + 2 + i) % HN] !== exp_ch[i]) begin
          failures++; $display("FAIL rnd%0d_addr[%0d] got=%0d/%0d exp=%0d/%0d", j, i,
                               bg_hist[(t + 2 + i) % HN], ch_hist[(t + 2 + i) % HN], exp_bg[i], exp_ch[i]);
        end
      end
      checks++;
      if (got_q.size() != exp_q.size()) begin
        failures++; $display("FAIL rnd%0d_count got=%0d exp=%0d", j, got_q.size(), exp_q.size());
      end
      foreach (exp_q[k]) if (k < got_q.size()) begin
        checks++;
        if (got_q[k] !== exp_q[k]) begin
          failures++; $display("FAIL rnd%0d_pix[%0d] got=%h exp=%h", j, k, got_q[k], exp_q[k]);
        end
      end
      checks++;
      if ((bg ? dbg_q.size() : dch_q.size()) != 1 || (bg ? dbg_q[0] : dch_q[0]) != t + 67 ||
          (bg ? dch_q.size() : dbg_q.size()) != 0) begin
        failures++; $display("FAIL rnd%0d_done got=bg%0d/ch%0d exp=%0d@%0d", j,
                             dbg_q.size(), dch_q.size(), bg, t + 67);
      end
    end
  endtask

  initial begin
    fill_char_rom();
    test_reset();
    test_bg();
    test_char();
    test_clip();
    test_both();
    test_held();
    test_midreset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sprite_drawer.md
# sprite_drawer

Responder side of the character move/draw handshake. Accepts a level-held `drawChar` or `drawBG` request with the sprite's (X,Y), streams a SPRITE_W×SPRITE_H block of pixels from the character ROM or the full-screen background ROM into the 320×240 VGA adapter, and returns a one-cycle `doneChar`/`doneBG` pulse. Sits between the sprite-move controller and the VGA adapter/ROMs.

## Interface
- SPRITE_W, 8, sprite width in pixels (power of 2)
- SPRITE_H, 8, sprite height in pixels (power of 2)
- COLOUR_BITS, 9, pixel colour width
- TRANSPARENT_COLOUR, 0, colour key for the character sprite
- clock  in  1  system clock
- resetn  in  1  synchronous, active-low reset
- drawChar  in  1  request: draw character; held until doneChar
- drawBG  in  1  request: redraw background under sprite; held until doneBG
- xCoordinate  in  9  sprite top-left X
- yCoordinate  in  8  sprite top-left Y
- doneChar  out  1  one-cycle pulse, character draw complete
- doneBG  out  1  one-cycle pulse, background draw complete
- char_addr  out  log2(W·H)  character ROM address, registered
- char_data  in  COLOUR_BITS  character ROM data, valid the cycle after char_addr
- bg_addr  out  17  background ROM address, registered, = y·320 + x
- bg_data  in  COLOUR_BITS  background ROM data, valid the cycle after bg_addr
- vga_x  out  9  plot X
- vga_y  out  8  plot Y
- vga_colour  out  COLOUR_BITS  plot colour
- vga_plot  out  1  write enable to VGA adapter
- busy  out  1  high in every state except IDLE

## Operation
- States: IDLE, LOAD, FETCH, DRAIN, DONE, RELEASE.
- IDLE: drawBG high → BG job; else drawChar high → CHAR job; else stay. drawBG wins if both high.
- LOAD: latch xCoordinate/yCoordinate into x0/y0 and job type; clear cx, cy. Later input changes ignored until next job.
- FETCH: each cycle present address for pixel (cx,cy), row-major (cx fastest). CHAR: char_addr = cy·SPRITE_W + cx. BG: bg_addr = (y0+cy)·320 + (x0+cx), 17-bit, computed at 9/8-bit+carry width (no wrap). Stay N = SPRITE_W·SPRITE_H cycles, then DRAIN.
- Pixel pipeline: one stage delays (px,py,valid,job); vga_x/vga_y/vga_colour/vga_plot driven from that stage plus ROM data in the following cycle.
- Clipping: pixel with px ≥ 320 or py ≥ 240 → vga_plot 0, ROM address forced 0.
- DRAIN: last pixel plotted. DONE: pulse doneBG or doneChar (matching job) for exactly one cycle.
- RELEASE: wait until both drawChar and drawBG low, then IDLE. Prevents a held request from retriggering.
- Reset (any state, incl. mid-draw): state IDLE, counters 0, doneChar/doneBG 0, vga_plot 0, vga_x/vga_y/vga_colour 0, char_addr/bg_addr 0, busy 0. A partially drawn block is not resumed.

## Timing
- Request high at edge t (IDLE) → LOAD at t+1, FETCH t+2…t+N+1, pixel i address at t+2+i, plot at t+3+i, DRAIN t+N+2, done pulse at t+N+3, RELEASE from t+N+4.
- Default N=64: done at t+67; 64 plot cycles, contiguous.
- vga_plot never high outside FETCH+1…DRAIN window.
- Minimum request-to-request spacing: N+5 cycles.

## Configuration
- SPRITE_TRANSPARENCY_EN defined: in CHAR jobs, pixels whose char_data == TRANSPARENT_COLOUR are not plotted (vga_plot 0); timing unchanged. BG jobs unaffected.
- Undefined: every in-bounds pixel of both jobs is plotted; TRANSPARENT_COLOUR unused.

## Test plan
- BG at (95,221), drawBG held: 64 plots, first bg_addr 70815 at t+2, first plot (95,221) at t+3, last (102,228), doneBG pulse at t+67, doneChar stays 0.
- CHAR at (126,68) with ROM words 0 at indices 0–7, nonzero else: with SPRITE_TRANSPARENCY_EN 56 plots (row 0 skipped); without, 64 plots; doneChar at t+67 either way.
- Clipping at (316,236): exactly 16 plots (x 316–319, y 236–239), all clipped cycles bg_addr 0, done still at t+67.
- drawBG and drawChar both high: BG job first, doneBG only; with drawChar still high after drawBG drops, no new job until drawChar also drops (RELEASE), then request again → CHAR job.
- Request held 20 cycles past done: exactly one job, no second plot burst.
- resetn low at t+30 of a BG job: next cycle all outputs 0, state IDLE, no done pulse; new drawBG afterwards completes normally with 64 plots.
